// File: rtl/rle_stream_fetcher_pkg.sv
// Shared definitions for the RLE stream fetcher: token layout and FSM states.
package rle_stream_fetcher_pkg;

    localparam int TOKEN_W    = 16;
    localparam int COLOUR_MSB = 15;
    localparam int COLOUR_LSB = 10;
    localparam int LEN_MSB    = 9;
    localparam int COLOUR_W   = COLOUR_MSB - COLOUR_LSB + 1;
    localparam int LEN_W      = LEN_MSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_PUSH   = 3'd4,
        ST_GAP    = 3'd5
    } fetch_state_e;

    // A zero run length marks the end of the compressed stream.
    function automatic logic tok_is_end(input logic [TOKEN_W-1:0] tok);
        return (tok[LEN_MSB:0] == {LEN_W{1'b0}});
    endfunction

endpackage

// File: rtl/rle_token_fifo.sv
// Synchronous token FIFO with flush, occupancy count and free-space outputs.
module rle_token_fifo
    import rle_stream_fetcher_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [TOKEN_W-1:0]       push_data_i,
    input  logic                     pop_i,
    output logic [TOKEN_W-1:0]       head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   free_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TOKEN_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push_s, do_pop_s;

    // Qualify push/pop and compute next pointers/count; flush wins over both.
    always_comb begin
        do_pop_s  = pop_i && (count_q != {CNT_W{1'b0}});
        do_push_s = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Token storage; contents are never observed while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign free_o  = CNT_W'(DEPTH) - count_q;

endmodule

// File: rtl/rle_stream_fetcher.sv
// Streams 32-bit flash words, splits them into two RLE tokens (upper first)
// and offers them to the pixel generator over valid/ready.
module rle_stream_fetcher
    import rle_stream_fetcher_pkg::*;
#(
    parameter int                   ADDR_BITS  = 16,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR  = 16'h0000,
    parameter int                   FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 frame_start_i,
    output logic [ADDR_BITS-1:0] flash_addr_o,
    output logic                 flash_start_o,
    output logic                 flash_continue_o,
    output logic                 flash_stop_o,
    input  logic [31:0]          flash_data_i,
    input  logic                 flash_busy_i,
    output logic                 tok_valid_o,
    input  logic                 tok_ready_i,
    output logic [COLOUR_W-1:0]  tok_colour_o,
    output logic [LEN_W-1:0]     tok_len_o,
    output logic                 eos_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e         state_q, state_d;
    logic [31:0]          word_q, word_d;
    logic                 half_q, half_d;     // 1: lower halfword still to push
    logic                 eos_q, eos_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;

    logic                 push_s, flush_s, start_s, cont_s, stop_s;
    logic [TOKEN_W-1:0]   push_data_s;
    logic [TOKEN_W-1:0]   head_s;
    logic [CNT_W-1:0]     count_s, free_s;

    rle_token_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (flush_s),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (tok_ready_i),
        .head_o      (head_s),
        .count_o     (count_s),
        .free_o      (free_s)
    );

    // Next-state and handshake decode; frame_start overrides every state.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        half_d      = half_q;
        eos_d       = eos_q;
        addr_d      = addr_q;
        push_s      = 1'b0;
        push_data_s = word_q[31:16];
        flush_s     = 1'b0;
        start_s     = 1'b0;
        cont_s      = 1'b0;
        stop_s      = 1'b0;
        if (frame_start_i) begin
            flush_s = 1'b1;
            stop_s  = 1'b1;
            eos_d   = 1'b0;
            word_d  = 32'h0000_0000;
            half_d  = 1'b0;
            addr_d  = BASE_ADDR;
            state_d = ST_START;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    stop_s  = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_START: begin
                    start_s = 1'b1;
                    state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    // Controller raises busy one cycle late, so do not look yet.
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (!flash_busy_i) begin
                        word_d  = flash_data_i;
                        half_d  = 1'b0;
                        state_d = ST_PUSH;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_PUSH: begin
                    push_s      = 1'b1;
                    push_data_s = half_q ? word_q[15:0] : word_q[31:16];
                    if (tok_is_end(push_data_s)) begin
                        eos_d   = 1'b1;
                        half_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (half_q) begin
                        half_d  = 1'b0;
                        state_d = ST_GAP;
                    end else begin
                        half_d  = 1'b1;
                        state_d = ST_PUSH;
                    end
                end
                ST_GAP: begin
                    // Room for a whole word guarantees PUSH can never overflow.
                    if (free_s >= CNT_W'(2)) begin
                        cont_s  = 1'b1;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            word_q  <= 32'h0000_0000;
            half_q  <= 1'b0;
            eos_q   <= 1'b0;
            addr_q  <= {ADDR_BITS{1'b0}};
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            half_q  <= half_d;
            eos_q   <= eos_d;
            addr_q  <= addr_d;
        end
    end

    assign flash_addr_o     = addr_q;
    assign flash_start_o    = start_s;
    assign flash_continue_o = cont_s;
    assign flash_stop_o     = stop_s;
    assign tok_valid_o      = (count_s != {CNT_W{1'b0}});
    assign tok_colour_o     = tok_valid_o ? head_s[COLOUR_MSB:COLOUR_LSB] : {COLOUR_W{1'b0}};
    assign tok_len_o        = tok_valid_o ? head_s[LEN_MSB:0] : {LEN_W{1'b0}};
    assign eos_o            = eos_q;

endmodule

// File: tb/tb_rle_stream_fetcher.sv
// Self-checking bench: flash controller model, token-order reference model
// derived from the flash image, and directed scenarios.
module tb_rle_stream_fetcher;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        frame_start = 1'b0;
    logic        tok_ready = 1'b0;
    logic [15:0] flash_addr;
    logic        flash_start, flash_continue, flash_stop;
    logic [31:0] flash_data;
    logic        flash_busy;
    logic        tok_valid;
    logic [5:0]  tok_colour;
    logic [9:0]  tok_len;
    logic        eos;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rle_stream_fetcher dut (
        .clk              (clk),
        .rstn             (rstn),
        .frame_start_i    (frame_start),
        .flash_addr_o     (flash_addr),
        .flash_start_o    (flash_start),
        .flash_continue_o (flash_continue),
        .flash_stop_o     (flash_stop),
        .flash_data_i     (flash_data),
        .flash_busy_i     (flash_busy),
        .tok_valid_o      (tok_valid),
        .tok_ready_i      (tok_ready),
        .tok_colour_o     (tok_colour),
        .tok_len_o        (tok_len),
        .eos_o            (eos)
    );

    // Flash controller model: busy rises the cycle after start/continue,
    // stays high 3 cycles, then data is valid and held; stop aborts a read.
    logic [31:0] img [0:127];
    int          fl_idx = 0;
    int          fl_cnt = 0;
    logic        fl_busy = 1'b0;
    logic [31:0] fl_data = 32'hDEAD_BEEF;
    assign flash_busy = fl_busy;
    assign flash_data = fl_data;

    always @(posedge clk) begin
        if (flash_stop === 1'b1) begin
            fl_busy <= 1'b0;
            fl_cnt  <= 0;
        end else if (flash_start === 1'b1 || flash_continue === 1'b1) begin
            fl_busy <= 1'b1;
            fl_cnt  <= 3;
            fl_data <= 32'hDEAD_BEEF;
            fl_idx  <= (flash_start === 1'b1) ? 0 : fl_idx + 1;
        end else if (fl_cnt > 0) begin
            fl_cnt <= fl_cnt - 1;
            if (fl_cnt == 1) begin
                fl_busy <= 1'b0;
                fl_data <= img[fl_idx % 128];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // k-th token of a frame: halfword k of the flash image, upper half first.
    function automatic logic [15:0] exp_tok(input int k);
        logic [31:0] w;
        w = img[(k / 2) % 128];
        return ((k % 2) == 0) ? w[31:16] : w[15:0];
    endfunction

    logic [15:0] acc_q [$];
    int          n_start = 0;
    int          n_cont  = 0;

    // Per-cycle compare process, sampling on the falling edge.
    initial begin
        logic        prev_rst, prev_fs, prev_hold, ended;
        logic [15:0] prev_tok, cur_tok;
        int          exp_k;
        prev_rst = 1'b0; prev_fs = 1'b0; prev_hold = 1'b0; ended = 1'b0;
        prev_tok = 16'h0; exp_k = 0;
        forever begin
            @(negedge clk);
            cur_tok = {tok_colour, tok_len};
            if (flash_start === 1'b1) n_start++;
            if (flash_continue === 1'b1) n_cont++;
            if (prev_rst) begin
                check("rst_valid", tok_valid, 0);
                check("rst_colour", tok_colour, 0);
                check("rst_len", tok_len, 0);
                check("rst_eos", eos, 0);
                check("rst_start", flash_start, 0);
                check("rst_cont", flash_continue, 0);
                check("rst_stop", flash_stop, 1);
                check("rst_addr", flash_addr, 0);
            end
            if (!rstn) begin
                prev_rst = 1'b1; prev_fs = 1'b0; prev_hold = 1'b0;
                ended = 1'b0; exp_k = 0;
                acc_q.delete();
            end else begin
                prev_rst = 1'b0;
                if (prev_fs) begin
                    check("fs_next_valid", tok_valid, 0);
                    check("fs_next_start", flash_start, 1);
                    check("fs_next_eos", eos, 0);
                end
                if (frame_start) begin
                    check("fs_stop", flash_stop, 1);
                    check("fs_no_start", flash_start, 0);
                    check("fs_no_cont", flash_continue, 0);
                    prev_fs = 1'b1; prev_hold = 1'b0;
                    ended = 1'b0; exp_k = 0;
                    acc_q.delete();
                end else begin
                    prev_fs = 1'b0;
                    if (prev_hold) begin
                        check("hold_valid", tok_valid, 1);
                        check("hold_token", cur_tok, prev_tok);
                    end
                    if (tok_valid && tok_ready) begin
                        check("tok_after_eos", ended, 0);
                        if (!ended) begin
                            check($sformatf("token_%0d", exp_k), cur_tok, exp_tok(exp_k));
                            if (tok_len == 10'd0) begin
                                check("eos_with_end_tok", eos, 1);
                                ended = 1'b1;
                            end
                            exp_k++;
                        end
                        acc_q.push_back(cur_tok);
                    end
                    prev_hold = tok_valid && !tok_ready;
                    prev_tok  = cur_tok;
                end
            end
        end
    end

    int cont_snap = 0;
    int start_snap = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        cont_snap   = n_cont;
        start_snap  = n_start;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int i = 0;
        while (acc_q.size() < n && i < budget) begin
            step(1);
            i++;
        end
        check(name, (acc_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Directed scenarios.
    initial begin
        logic [15:0] t;
        logic [15:0] hi, lo;
        int          a0, i;
        img[0] = 32'hFC05_0A03;
        for (int w = 1; w < 128; w++) begin
            hi = {6'(w), 10'((w * 37) % 1000 + 1)};
            lo = {6'(w + 7), 10'((w * 53) % 1000 + 1)};
            img[w] = {hi, lo};
        end

        step(3);
        rstn = 1'b1;
        step(2);

        // Single word, consumer always ready.
        tok_ready = 1'b1;
        pulse_frame();
        wait_acc(2, 100, "t1_wait");
        t = acc_q[0];
        check("t1_colour0", t[15:10], 63);
        check("t1_len0", t[9:0], 5);
        t = acc_q[1];
        check("t1_colour1", t[15:10], 2);
        check("t1_len1", t[9:0], 10'h203);
        check("t1_starts", n_start - start_snap, 1);
        check("t1_conts", n_cont - cont_snap, 1);

        // Consumer stalled: FIFO fills to 4, no continue while free < 2.
        tok_ready = 1'b0;
        pulse_frame();
        step(80);
        check("t2_conts", n_cont - cont_snap, 1);
        check("t2_valid", tok_valid, 1);
        check("t2_busy", flash_busy, 0);
        a0 = acc_q.size();
        tok_ready = 1'b1;
        step(4);
        tok_ready = 1'b0;
        check("t2_drained4", acc_q.size() - a0, 4);
        check("t2_empty", tok_valid, 0);

        // End-of-stream in the lower halfword.
        img[0] = 32'h0403_0000;
        tok_ready = 1'b1;
        pulse_frame();
        wait_acc(2, 100, "t3_wait");
        t = acc_q[0];
        check("t3_colour0", t[15:10], 1);
        check("t3_len0", t[9:0], 3);
        check("t3_end_tok", acc_q[1], 16'h0000);
        step(20);
        check("t3_eos", eos, 1);
        check("t3_stop", flash_stop, 1);
        check("t3_valid", tok_valid, 0);
        check("t3_no_cont", n_cont - cont_snap, 0);
        check("t3_count", acc_q.size(), 2);

        // frame_start while a continue read is in flight, 2 tokens queued.
        img[0] = 32'hFC05_0A03;
        tok_ready = 1'b0;
        pulse_frame();
        i = 0;
        while (n_cont == cont_snap && i < 60) begin
            step(1);
            i++;
        end
        check("t4_cont_seen", n_cont - cont_snap, 1);
        step(1);
        check("t4_in_wait", flash_busy, 1);
        pulse_frame();
        tok_ready = 1'b1;
        wait_acc(2, 100, "t4_wait");
        check("t4_tok0", acc_q[0], 16'hFC05);
        check("t4_tok1", acc_q[1], 16'h0A03);

        // Reset while pushing, then a clean restart.
        pulse_frame();
        i = 0;
        while (fl_busy == 1'b0 && i < 20) begin step(1); i++; end
        while (fl_busy == 1'b1 && i < 40) begin step(1); i++; end
        check("t5_read_done", (i < 40) ? 32'd1 : 32'd0, 32'd1);
        step(1);
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
        check("t5_valid", tok_valid, 0);
        check("t5_stop", flash_stop, 1);
        check("t5_acc", acc_q.size(), 0);
        step(1);
        pulse_frame();
        wait_acc(2, 100, "t5_wait");
        check("t5_tok0", acc_q[0], 16'hFC05);

        // Random back-pressure over 64 words.
        pulse_frame();
        i = 0;
        while (acc_q.size() < 128 && i < 4000) begin
            tok_ready = 1'($urandom_range(0, 1));
            step(1);
            i++;
        end
        check("t6_all_tokens", (acc_q.size() >= 128) ? 32'd1 : 32'd0, 32'd1);
        tok_ready = 1'b0;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
